// File: rtl/wb_copy_master.sv
// Wishbone classic single-beat copy initiator: moves len_i 32-bit words
// from src_i to dst_i word addresses, one read then one write per word.
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   start_i, src_i, dst_i,    command strobe and operands (sampled in IDLE)
//   len_i
//   busy_o, done_o, err_o     command status; err_o qualifies done_o
//   cyc_o, stb_o, we_o,       Wishbone initiator outputs
//   sel_o, adr_o, dat_o
//   dat_i, ack_i              Wishbone responder inputs
//
// Optional: define WB_COPY_TIMEOUT_EN to enable the ack watchdog
// (TIMEOUT cycles of unacknowledged strobe aborts the command with err_o).
module wb_copy_master #(
    parameter int AWIDTH  = 15,
    parameter int LWIDTH  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] src_i,
    input  logic [AWIDTH-1:0] dst_i,
    input  logic [LWIDTH-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [3:0]        sel_o,
    output logic [AWIDTH-1:0] adr_o,
    output logic [31:0]       dat_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDG,
        S_WR,
        S_WRG,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [AWIDTH-1:0] src_q, src_d;
    logic [AWIDTH-1:0] dst_q, dst_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic cyc_q, cyc_d;
    logic stb_q, stb_d;
    logic we_q, we_d;

`ifdef WB_COPY_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        err_d   = 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d   = src_i;
                    dst_d   = dst_i;
                    cnt_d   = len_i;
                    state_d = (len_i == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (ack_i) begin
                    dat_d   = dat_i;
                    state_d = S_RDG;
                end
`ifdef WB_COPY_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_RDG: begin
                state_d = S_WR;
            end
            S_WR: begin
                if (ack_i) begin
                    state_d = S_WRG;
                end
`ifdef WB_COPY_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_WRG: begin
                src_d   = src_q + AWIDTH'(1);
                dst_d   = dst_q + AWIDTH'(1);
                cnt_d   = cnt_q - LWIDTH'(1);
                state_d = (cnt_q == LWIDTH'(1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef WB_COPY_TIMEOUT_EN
        // Watchdog restarts on every fresh strobe phase.
        if ((state_d == S_RD || state_d == S_WR) && state_d != state_q) begin
            tmo_d = '0;
        end
`endif

        // Outputs are derived from the next state so they are registered.
        cyc_d  = (state_d == S_RD) || (state_d == S_RDG) ||
                 (state_d == S_WR) || (state_d == S_WRG);
        stb_d  = (state_d == S_RD) || (state_d == S_WR);
        we_d   = (state_d == S_WR);
        busy_d = cyc_d;
        done_d = (state_d == S_DONE);
        if (state_d == S_RD) begin
            adr_d = src_d;
        end else if (state_d == S_WR) begin
            adr_d = dst_d;
        end else begin
            adr_d = adr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
`ifdef WB_COPY_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign sel_o  = 4'hf;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: RAM responder with variable wait states,
// randomized copy commands checked against a sequential copy model.
module tb_wb_copy_master;

    localparam int AW  = 15;
    localparam int LW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] src_i = '0;
    logic [AW-1:0] dst_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, err_o;
    logic          cyc_o, stb_o, we_o;
    logic [3:0]    sel_o;
    logic [AW-1:0] adr_o;
    logic [31:0]   dat_o;
    logic [31:0]   dat_i;
    logic          ack_i = 1'b0;

    always #5 clk = ~clk;

    wb_copy_master #(
        .AWIDTH (AW),
        .LWIDTH (LW),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n_i),
        .start_i(start_i),
        .src_i  (src_i),
        .dst_i  (dst_i),
        .len_i  (len_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .err_o  (err_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .sel_o  (sel_o),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .dat_i  (dat_i),
        .ack_i  (ack_i)
    );

    logic [31:0] mem   [0:(1<<AW)-1];
    logic [31:0] ref_m [0:(1<<AW)-1];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // RAM responder: ack after rwait cycles of strobe, one-cycle ack.
    int rwait = 1;
    bit ack_en = 1'b1;
    int wcnt = 0;

    assign dat_i = mem[adr_o];

    always @(posedge clk) begin
        if (!(cyc_o && stb_o) || ack_i) begin
            ack_i <= 1'b0;
            wcnt  <= 0;
        end else if (ack_en && (wcnt + 1 >= rwait)) begin
            ack_i <= 1'b1;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Bus monitor: logs completed beats, performs RAM writes.
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_q[$];
    int done_n = 0;
    int err_n = 0;
    int stb_n = 0;
    int busy_n = 0;
    int sel_bad = 0;

    always @(negedge clk) begin
        if (cyc_o && stb_o && ack_i) begin
            if (we_o) begin
                wr_q.push_back(adr_o);
                mem[adr_o] = dat_o;
            end else begin
                rd_q.push_back(adr_o);
            end
            if (sel_o != 4'hf) sel_bad++;
        end
        if (stb_o) stb_n++;
        if (busy_o) busy_n++;
        if (done_o) begin
            done_n++;
            if (err_o) err_n++;
        end
    end

    task automatic clear_mon;
        rd_q.delete();
        wr_q.delete();
        done_n = 0;
        err_n  = 0;
        stb_n  = 0;
        busy_n = 0;
    endtask

    task automatic do_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [LW-1:0] n, input int w,
                           input bit again);
        logic [AW-1:0] er[$];
        logic [AW-1:0] ew[$];
        logic [AW-1:0] a, b;
        int k, bound, bad, exp_k;

        // Reference: ascending word-by-word copy on a snapshot of memory.
        for (int i = 0; i < (1 << AW); i++) ref_m[i] = mem[i];
        for (int i = 0; i < int'(n); i++) begin
            a = s + AW'(i);
            b = d + AW'(i);
            ref_m[b] = ref_m[a];
            er.push_back(a);
            ew.push_back(b);
        end
        exp_k = 1 + (2 * w + 4) * int'(n);
        bound = exp_k + 20;

        clear_mon();
        rwait   = w;
        src_i   = s;
        dst_i   = d;
        len_i   = n;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        src_i   = AW'($urandom);
        dst_i   = AW'($urandom);
        len_i   = LW'($urandom_range(1, 9));
        k = 1;
        while (done_n == 0 && k < bound) begin
            start_i = again && (k == 3);
            tick;
            k++;
        end
        start_i = 1'b0;

        chk("done_seen", done_n, 1);
        chk("latency", k, exp_k);
        chk("err_clear", err_n, 0);
        chk("stb_cycles", stb_n, 2 * (w + 1) * int'(n));
        if (n == 0) chk("len0_busy", busy_n, 0);

        // Strobe during the DONE cycle must not start a command.
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        repeat (3) tick;
        chk("done_start_ign", {busy_o, stb_o, cyc_o}, 3'b000);
        chk("done_once", done_n, 1);

        chk("rd_count", rd_q.size(), er.size());
        chk("wr_count", wr_q.size(), ew.size());
        for (int i = 0; i < er.size() && i < rd_q.size(); i++)
            chk($sformatf("rd_adr%0d", i), rd_q[i], er[i]);
        for (int i = 0; i < ew.size() && i < wr_q.size(); i++)
            chk($sformatf("wr_adr%0d", i), wr_q[i], ew[i]);
        bad = 0;
        for (int i = 0; i < (1 << AW); i++)
            if (mem[i] !== ref_m[i]) bad++;
        chk("mem", bad, 0);
        chk("sel", sel_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

        // Reset held with start asserted.
        rst_n_i = 1'b0;
        start_i = 1'b1;
        src_i   = 15'h0010;
        len_i   = 16'd4;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("rst_ctl%0d", i),
                {cyc_o, stb_o, busy_o, done_o, err_o}, 5'b0);
        end
        chk("rst_adr", adr_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_sel", sel_o, 4'hf);
        start_i = 1'b0;
        rst_n_i = 1'b1;
        tick;

        // Directed: basic copy, zero length, address wrap, overlap.
        for (int i = 0; i < 4; i++) mem[15'h10 + i] = 32'ha0 + i;
        do_copy(15'h0010, 15'h0020, 16'd4, 1, 1'b0);
        chk("copy_a3", mem[15'h23], 32'ha3);
        do_copy(15'h0030, 15'h0040, 16'd0, 1, 1'b0);
        do_copy(15'h7ffe, 15'h0100, 16'd3, 1, 1'b0);
        do_copy(15'h0040, 15'h0042, 16'd5, 1, 1'b0);

        // Second start while busy is ignored.
        do_copy(15'h0200, 15'h0280, 16'd3, 1, 1'b1);

        // Randomized commands with random wait states.
        for (int r = 0; r < 6; r++)
            do_copy(AW'($urandom), AW'($urandom),
                    LW'($urandom_range(1, 6)), $urandom_range(1, 3),
                    1'($urandom_range(0, 1)));

        // Reset in the middle of a write phase.
        clear_mon();
        rwait   = 1;
        src_i   = 15'h0500;
        dst_i   = 15'h0600;
        len_i   = 16'd3;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        k = 0;
        while (!we_o && k < 40) begin
            tick;
            k++;
        end
        chk("mid_wr_reached", we_o, 1'b1);
        rst_n_i = 1'b0;
        tick;
        chk("mid_rst_bus", {cyc_o, stb_o, busy_o, done_o}, 4'b0);
        rst_n_i = 1'b1;
        repeat (10) tick;
        chk("mid_rst_nodone", done_n, 0);
        do_copy(15'h0500, 15'h0600, 16'd3, 1, 1'b0);

        // Responder that never acknowledges.
        clear_mon();
        ack_en  = 1'b0;
        src_i   = 15'h0700;
        dst_i   = 15'h0780;
        len_i   = 16'd2;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
        k = 1;
        while (done_n == 0 && k < 60) begin
            tick;
            k++;
        end
        chk("tmo_done", done_n, 1);
        chk("tmo_err", err_n, 1);
        chk("tmo_stb", stb_n, TMO);
        chk("tmo_nowr", wr_q.size(), 0);
        tick;
        chk("tmo_idle", {busy_o, cyc_o, err_o}, 3'b000);
`else
        repeat (100) tick;
        chk("hang_bus", {cyc_o, stb_o, busy_o}, 3'b111);
        chk("hang_nodone", done_n, 0);
        rst_n_i = 1'b0;
        tick;
        rst_n_i = 1'b1;
        tick;
`endif
        ack_en = 1'b1;
        do_copy(15'h0700, 15'h0780, 16'd2, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
